// File: rtl/lcd_instr_arbiter_if.sv
// rtl/lcd_instr_arbiter_if.sv - requester and instruction-FSM signal bundle for the LCD arbiter
interface lcd_instr_arbiter_if;
    logic       init_done;
    logic       req0;
    logic       req1;
    logic       lock0;
    logic       lock1;
    logic [9:0] instr0;
    logic [9:0] instr1;
    logic       ack0;
    logic       ack1;
    logic       gnt_id;
    logic       locked;
    logic       busy;
    logic       instr_fsm_enable;
    logic [9:0] instruction;
    logic       instr_fsm_done;

    modport slave (
        input  init_done, req0, req1, lock0, lock1, instr0, instr1, instr_fsm_done,
        output ack0, ack1, gnt_id, locked, busy, instr_fsm_enable, instruction
    );

    modport master (
        output init_done, req0, req1, lock0, lock1, instr0, instr1, instr_fsm_done,
        input  ack0, ack1, gnt_id, locked, busy, instr_fsm_enable, instruction
    );
endinterface

// File: rtl/lcd_instr_arbiter.sv
// rtl/lcd_instr_arbiter.sv - round-robin, lockable two-port arbiter in front of the LCD instruction FSM
module lcd_instr_arbiter #(
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    lcd_instr_arbiter_if.slave bus
);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    state_t        state, state_d;
    logic [9:0]    instr_q, instr_d;
    logic          lock_bit_q, lock_bit_d;
    logic          gnt_q, gnt_d;
    logic          locked_q, locked_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          owner_req;
    logic          win_valid;
    logic          win_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            instr_q    <= '0;
            lock_bit_q <= 1'b0;
            gnt_q      <= 1'b1;
            locked_q   <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state      <= state_d;
            instr_q    <= instr_d;
            lock_bit_q <= lock_bit_d;
            gnt_q      <= gnt_d;
            locked_q   <= locked_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            cnt_q      <= cnt_d;
        end
    end

    // Winner selection: the lock owner alone while locked, otherwise round-robin on ties.
    always_comb begin
        owner_req = gnt_q ? bus.req1 : bus.req0;
        win_valid = 1'b0;
        win_id    = gnt_q;
        if (locked_q) begin
            win_valid = owner_req;
            win_id    = gnt_q;
        end else if (bus.req0 && bus.req1) begin
            win_valid = 1'b1;
            win_id    = ~gnt_q;
        end else if (bus.req0) begin
            win_valid = 1'b1;
            win_id    = 1'b0;
        end else if (bus.req1) begin
            win_valid = 1'b1;
            win_id    = 1'b1;
        end
    end

    always_comb begin
        state_d    = state;
        instr_d    = instr_q;
        lock_bit_d = lock_bit_q;
        gnt_d      = gnt_q;
        locked_d   = locked_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        cnt_d      = '0;
        case (state)
            IDLE: begin
                // An idle lock ages out; the release is visible one cycle later.
                if (locked_q && !owner_req && bus.init_done) begin
                    if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        locked_d = 1'b0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                if (bus.init_done && win_valid) begin
                    state_d    = ISSUE;
                    instr_d    = win_id ? bus.instr1 : bus.instr0;
                    lock_bit_d = win_id ? bus.lock1 : bus.lock0;
                    gnt_d      = win_id;
                end
            end
            ISSUE: begin
                if (bus.instr_fsm_done) begin
                    state_d  = ACK;
                    locked_d = lock_bit_q;
                    ack0_d   = ~gnt_q;
                    ack1_d   = gnt_q;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.instruction      = instr_q;
    assign bus.ack0             = ack0_q;
    assign bus.ack1             = ack1_q;
    assign bus.gnt_id           = gnt_q;
    assign bus.locked           = locked_q;
    assign bus.busy             = (state != IDLE);
    // Masking with done keeps the FSM from seeing a second start on its completion cycle.
    assign bus.instr_fsm_enable = (state == ISSUE) && !bus.instr_fsm_done;
endmodule

// File: tb/tb_lcd_instr_arbiter.sv
// tb/tb_lcd_instr_arbiter.sv - self-checking bench for lcd_instr_arbiter with a grant-order reference model
module tb_lcd_instr_arbiter;
    logic       clk;
    logic       reset;
    logic       init_done;
    logic [1:0] req_v;
    logic [1:0] lock_v;
    logic [9:0] instr_v [2];
    logic       fsm_auto;
    logic       done_auto;
    logic       done_manual;
    int         lat;

    int errors = 0;
    int checks = 0;

    int en_rises  = 0;
    int ack_total = 0;
    int ack0_cnt  = 0;
    int ack1_cnt  = 0;
    logic prev_en;

    int         log_id  [$];
    logic [9:0] log_ins [$];
    logic       log_lk  [$];
    int         exp_id  [$];
    logic [9:0] exp_ins [$];
    logic       exp_lk  [$];
    int         exp_last;

    logic [9:0] seq_instr [2][64];
    logic       seq_lock  [2][64];
    int         seq_n     [2];

    lcd_instr_arbiter_if bus ();

    assign bus.init_done      = init_done;
    assign bus.req0           = req_v[0];
    assign bus.req1           = req_v[1];
    assign bus.lock0          = lock_v[0];
    assign bus.lock1          = lock_v[1];
    assign bus.instr0         = instr_v[0];
    assign bus.instr1         = instr_v[1];
    assign bus.instr_fsm_done = fsm_auto ? done_auto : done_manual;

    lcd_instr_arbiter #(.LOCK_TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction FSM stand-in: finishes after lat cycles of enable.
    initial begin
        int rcnt;
        rcnt = 0;
        done_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (!fsm_auto || reset) begin
                done_auto = 1'b0;
                rcnt = 0;
            end else if (done_auto) begin
                done_auto = 1'b0;
                rcnt = 0;
            end else if (bus.instr_fsm_enable) begin
                rcnt++;
                if (rcnt >= lat) done_auto = 1'b1;
            end
        end
    end

    initial begin
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_en = 1'b0;
            end else begin
                if (bus.instr_fsm_enable && !prev_en) en_rises++;
                prev_en = bus.instr_fsm_enable;
                if (bus.ack0 || bus.ack1) begin
                    log_id.push_back(bus.ack1 ? 1 : 0);
                    log_ins.push_back(bus.instruction);
                    log_lk.push_back(bus.locked);
                    ack_total++;
                    if (bus.ack0) ack0_cnt++;
                    if (bus.ack1) ack1_cnt++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k);
        for (int i = 0; i < seq_n[k]; i++) begin
            int   w;
            logic got;
            req_v[k]   = 1'b1;
            lock_v[k]  = seq_lock[k][i];
            instr_v[k] = seq_instr[k][i];
            w   = 0;
            got = 1'b0;
            while (!got && w < 400) begin
                @(negedge clk);
                w++;
                got = (k == 1) ? bus.ack1 : bus.ack0;
            end
            if (!got) begin
                chk($sformatf("ack_wait_req%0d", k), got, 1);
                break;
            end
        end
        req_v[k]  = 1'b0;
        lock_v[k] = 1'b0;
    endtask

    task automatic fill_rand(input int k, input int groups, input bit allow_lock);
        int sz;
        seq_n[k] = 0;
        for (int g = 0; g < groups; g++) begin
            sz = allow_lock ? $urandom_range(1, 3) : 1;
            for (int j = 0; j < sz; j++) begin
                seq_instr[k][seq_n[k]] = 10'($urandom_range(0, 1023));
                seq_lock[k][seq_n[k]]  = (j != sz - 1);
                seq_n[k]++;
            end
        end
    endtask

    // Both requesters always pending: whole lock groups alternate, the non-last winner first.
    task automatic build_expected();
        int   pos [2];
        int   pick;
        logic lk;
        pos[0] = 0;
        pos[1] = 0;
        exp_id.delete();
        exp_ins.delete();
        exp_lk.delete();
        while (pos[0] < seq_n[0] || pos[1] < seq_n[1]) begin
            if (pos[0] < seq_n[0] && pos[1] < seq_n[1]) pick = 1 - exp_last;
            else if (pos[0] < seq_n[0])                 pick = 0;
            else                                        pick = 1;
            do begin
                lk = seq_lock[pick][pos[pick]];
                exp_id.push_back(pick);
                exp_ins.push_back(seq_instr[pick][pos[pick]]);
                exp_lk.push_back(lk);
                pos[pick]++;
            end while (lk && pos[pick] < seq_n[pick]);
            exp_last = pick;
        end
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, ".count"}, log_id.size(), exp_id.size());
        for (int i = 0; i < exp_id.size() && i < log_id.size(); i++) begin
            chk($sformatf("%s[%0d].id", tag, i), log_id[i], exp_id[i]);
            chk($sformatf("%s[%0d].instr", tag, i), log_ins[i], exp_ins[i]);
            chk($sformatf("%s[%0d].locked", tag, i), log_lk[i], exp_lk[i]);
        end
    endtask

    task automatic run_seq(input string tag);
        int en0, a0, c0, c1, n0;
        build_expected();
        log_id.delete();
        log_ins.delete();
        log_lk.delete();
        en0 = en_rises;
        a0  = ack_total;
        c0  = ack0_cnt;
        c1  = ack1_cnt;
        fork
            drive(0);
            drive(1);
        join
        repeat (3) @(negedge clk);
        cmp_log(tag);
        n0 = 0;
        foreach (exp_id[i]) if (exp_id[i] == 0) n0++;
        chk({tag, ".ack0_count"}, ack0_cnt - c0, n0);
        chk({tag, ".ack1_count"}, ack1_cnt - c1, exp_id.size() - n0);
        chk({tag, ".enable_runs"}, en_rises - en0, ack_total - a0);
    endtask

    initial begin
        int   en_snap, ack_snap, w;
        logic got;

        reset       = 1'b1;
        init_done   = 1'b0;
        req_v       = 2'b00;
        lock_v      = 2'b00;
        instr_v[0]  = '0;
        instr_v[1]  = '0;
        fsm_auto    = 1'b0;
        done_manual = 1'b0;
        lat         = 2;
        exp_last    = 1;
        seq_n[0]    = 0;
        seq_n[1]    = 0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst.enable", bus.instr_fsm_enable, 0);
        chk("rst.instruction", bus.instruction, 0);
        chk("rst.ack0", bus.ack0, 0);
        chk("rst.ack1", bus.ack1, 0);
        chk("rst.gnt_id", bus.gnt_id, 1);
        chk("rst.locked", bus.locked, 0);
        chk("rst.busy", bus.busy, 0);

        // Held off by init_done, then a single manually completed instruction
        @(negedge clk);
        reset      = 1'b0;
        req_v[0]   = 1'b1;
        instr_v[0] = 10'h080;
        en_snap  = en_rises;
        ack_snap = ack_total;
        repeat (100) @(negedge clk);
        chk("init_low.enable_runs", en_rises - en_snap, 0);
        chk("init_low.busy", bus.busy, 0);
        init_done = 1'b1;
        #1;
        chk("init_up.enable_same_cycle", bus.instr_fsm_enable, 0);
        @(negedge clk);
        #1;
        chk("grant.enable", bus.instr_fsm_enable, 1);
        chk("grant.instruction", bus.instruction, 10'h080);
        chk("grant.gnt_id", bus.gnt_id, 0);
        chk("grant.busy", bus.busy, 1);
        @(negedge clk);
        done_manual = 1'b1;
        #1;
        chk("done.enable_masked", bus.instr_fsm_enable, 0);
        @(negedge clk);
        done_manual = 1'b0;
        req_v[0]    = 1'b0;
        #1;
        chk("ack.ack0", bus.ack0, 1);
        chk("ack.ack1", bus.ack1, 0);
        chk("ack.enable", bus.instr_fsm_enable, 0);
        chk("ack.locked", bus.locked, 0);
        @(negedge clk);
        #1;
        chk("post_ack.ack0", bus.ack0, 0);
        chk("post_ack.busy", bus.busy, 0);
        repeat (5) @(negedge clk);
        chk("single.enable_runs", en_rises - en_snap, 1);
        chk("single.acks", ack_total - ack_snap, 1);
        exp_last = 0;

        // Reset in the middle of ISSUE
        req_v[0]   = 1'b1;
        instr_v[0] = 10'h1A5;
        @(negedge clk);
        #1;
        chk("abort.enable_before", bus.instr_fsm_enable, 1);
        ack_snap = ack_total;
        reset    = 1'b1;
        req_v[0] = 1'b0;
        #1;
        chk("abort.enable_immediate", bus.instr_fsm_enable, 0);
        chk("abort.busy_immediate", bus.busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("abort.no_ack", ack_total - ack_snap, 0);
        chk("abort.instruction", bus.instruction, 0);
        chk("abort.gnt_id", bus.gnt_id, 1);
        chk("abort.locked", bus.locked, 0);
        chk("abort.busy", bus.busy, 0);
        exp_last = 1;

        // Saturated ties, no lock: strict alternation starting with requester 0
        fsm_auto = 1'b1;
        fill_rand(0, 4, 1'b0);
        fill_rand(1, 4, 1'b0);
        run_seq("alt");

        // Requester 1 locked pair ahead of a waiting requester 0
        seq_n[1] = 2;
        seq_instr[1][0] = 10'h0CF; seq_lock[1][0] = 1'b1;
        seq_instr[1][1] = 10'h2FF; seq_lock[1][1] = 1'b0;
        seq_n[0] = 1;
        seq_instr[0][0] = 10'h155; seq_lock[0][0] = 1'b0;
        exp_id.delete(); exp_ins.delete(); exp_lk.delete();
        exp_id.push_back(1); exp_ins.push_back(10'h0CF); exp_lk.push_back(1'b1);
        exp_id.push_back(1); exp_ins.push_back(10'h2FF); exp_lk.push_back(1'b0);
        exp_id.push_back(0); exp_ins.push_back(10'h155); exp_lk.push_back(1'b0);
        log_id.delete(); log_ins.delete(); log_lk.delete();
        fork
            drive(1);
            begin
                repeat (2) @(negedge clk);
                drive(0);
            end
        join
        repeat (3) @(negedge clk);
        cmp_log("lock");
        exp_last = 0;

        // Idle lock times out after 8 IDLE cycles
        req_v[0]   = 1'b1;
        lock_v[0]  = 1'b1;
        instr_v[0] = 10'h3C3;
        w   = 0;
        got = 1'b0;
        while (!got && w < 100) begin
            @(negedge clk);
            w++;
            got = bus.ack0;
        end
        chk("tmo.ack0_seen", got, 1);
        chk("tmo.locked_in_ack", bus.locked, 1);
        req_v[0]   = 1'b0;
        lock_v[0]  = 1'b0;
        req_v[1]   = 1'b1;
        lock_v[1]  = 1'b0;
        instr_v[1] = 10'h041;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("tmo.idle%0d.locked", i), bus.locked, 1);
            chk($sformatf("tmo.idle%0d.busy", i), bus.busy, 0);
        end
        @(negedge clk);
        chk("tmo.released", bus.locked, 0);
        chk("tmo.release_busy", bus.busy, 0);
        @(negedge clk);
        #1;
        chk("tmo.grant_busy", bus.busy, 1);
        chk("tmo.grant_gnt", bus.gnt_id, 1);
        chk("tmo.grant_enable", bus.instr_fsm_enable, 1);
        chk("tmo.grant_instr", bus.instruction, 10'h041);
        w   = 0;
        got = 1'b0;
        while (!got && w < 100) begin
            @(negedge clk);
            w++;
            got = bus.ack1;
        end
        chk("tmo.ack1_seen", got, 1);
        req_v[1] = 1'b0;
        exp_last = 1;
        repeat (3) @(negedge clk);

        // Random lock groups and FSM latencies against the grant-order model
        for (int r = 0; r < 4; r++) begin
            lat = $urandom_range(2, 4);
            fill_rand(0, $urandom_range(1, 4), 1'b1);
            fill_rand(1, $urandom_range(1, 4), 1'b1);
            run_seq($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
